// File: rtl/st_fifo_rr_packet_arbiter.sv
// Packet-aware round-robin arbiter feeding a single Avalon-ST FIFO write port.
// A source holds the grant from SOP through its accepted EOP. New grants are
// issued only while the downstream fill level is below FILL_THRESH. Data is
// muxed combinationally from the registered grant.
//
// state | meaning
// IDLE  | no grant held; arbitrate among SOP requests when FIFO has room
// LOCK  | grant held by one source until its EOP beat is accepted
module st_fifo_rr_packet_arbiter #(
   parameter int NUM_IN      = 4,
   parameter int DATA_WIDTH  = 256,
   parameter int CH_WIDTH    = 2,
   parameter int FILL_WIDTH  = 4,
   parameter int FILL_THRESH = 6
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_IN-1:0]            in_valid,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]            in_sop,
   input  logic [NUM_IN-1:0]            in_eop,
   output logic [NUM_IN-1:0]            in_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [CH_WIDTH-1:0]          out_channel,
   input  logic                         out_ready,
   input  logic [FILL_WIDTH-1:0]        fill_level,
   output logic                         grant_active,
   output logic [15:0]                  pkt_count
);

   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t            state;
   logic [SEL_W-1:0]  grant;
   logic [SEL_W-1:0]  last_grant;
   logic [SEL_W-1:0]  next_grant;
   logic [NUM_IN-1:0] req;
   logic              any_req;
   logic              room;
   logic              lock;
   logic              beat_acc;
   int                idx;

   assign req      = in_valid & in_sop;
   assign room     = int'(fill_level) < FILL_THRESH;
   assign lock     = (state == LOCK);
   assign beat_acc = lock & in_valid[grant] & out_ready;

   // Round-robin search starting just after the last completed source; the
   // loop runs from the farthest offset down so the nearest requester wins.
   always_comb begin
      next_grant = '0;
      any_req    = 1'b0;
      idx        = 0;
      for (int k = NUM_IN; k >= 1; k--) begin
         idx = (int'(last_grant) + k) % NUM_IN;
         if (req[SEL_W'(idx)]) begin
            next_grant = SEL_W'(idx);
            any_req    = 1'b1;
         end
      end
   end

   // Output mux: only the granted source is visible, and only while locked.
   always_comb begin
      in_ready    = '0;
      out_valid   = 1'b0;
      out_sop     = 1'b0;
      out_eop     = 1'b0;
      out_channel = '0;
      out_data    = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      if (lock) begin
         in_ready[grant] = out_ready;
         out_valid       = in_valid[grant];
         out_sop         = in_sop[grant];
         out_eop         = in_eop[grant];
         out_channel     = CH_WIDTH'(grant);
      end
   end

   assign grant_active = lock;

   // Grant FSM, round-robin pointer and completed-packet counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= SEL_W'(NUM_IN - 1);
         pkt_count  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req && room) begin
                  grant <= next_grant;
                  state <= LOCK;
               end
            end
            LOCK: begin
               // A mid-packet SOP is just data; only an accepted EOP releases.
               if (beat_acc && in_eop[grant]) begin
                  state      <= IDLE;
                  last_grant <= grant;
                  pkt_count  <= pkt_count + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_st_fifo_rr_packet_arbiter.sv
// Directed bench for st_fifo_rr_packet_arbiter: a source model replays
// queued beats per source; expected output beats are pushed in predicted
// grant order and popped as the arbiter emits them.
module tb_st_fifo_rr_packet_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;

   typedef struct {
      int           src;
      logic [DW-1:0] data;
      logic         sop;
      logic         eop;
   } beat_t;

   logic            clk;
   logic            reset_n;
   logic [N-1:0]    in_valid;
   logic [N*DW-1:0] in_data;
   logic [N-1:0]    in_sop;
   logic [N-1:0]    in_eop;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic            out_sop;
   logic            out_eop;
   logic [1:0]      out_channel;
   logic            out_ready;
   logic [3:0]      fill_level;
   logic            grant_active;
   logic [15:0]     pkt_count;

   beat_t pend_q[$];
   beat_t exp_q[$];
   int    acc_log[$];
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   bit    hold_all = 0;
   logic [N-1:0] acc = '0;
   int    c0;

   st_fifo_rr_packet_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
      .out_eop(out_eop), .out_channel(out_channel), .out_ready(out_ready),
      .fill_level(fill_level), .grant_active(grant_active), .pkt_count(pkt_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input int n, input int n_exp, input int tag);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.src  = s;
         b.data = {8{32'(tag*256 + s*16 + k)}};
         b.sop  = (k == 0);
         b.eop  = (k == n-1);
         pend_q.push_back(b);
         if (k < n_exp) exp_q.push_back(b);
      end
   endtask

   function automatic bit src_pending(input int s);
      for (int j = 0; j < pend_q.size(); j++)
         if (pend_q[j].src == s) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_drain(input int budget, input string tag);
      int n;
      n = 0;
      while ((pend_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         tick(1);
         n++;
      end
      check(tag, 256'(exp_q.size()), 256'd0);
   endtask

   // Source model and output monitor, both on the falling edge.
   always @(negedge clk) begin
      beat_t b;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            for (int j = 0; j < pend_q.size(); j++) begin
               if (pend_q[j].src == i) begin
                  pend_q.delete(j);
                  break;
               end
            end
         end
      end
      in_valid = '0;
      in_sop   = '0;
      in_eop   = '0;
      in_data  = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < pend_q.size(); j++) begin
            if (pend_q[j].src == i) begin
               in_valid[i]          = 1'b1;
               in_sop[i]            = pend_q[j].sop;
               in_eop[i]            = pend_q[j].eop;
               in_data[i*DW +: DW]  = pend_q[j].data;
               break;
            end
         end
      end
      if (hold_all) in_valid = '1;
      #1;
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 256'(exp_q.size()), 256'd1);
         end else begin
            b = exp_q.pop_front();
            check("sb_channel", 256'(out_channel), 256'(b.src));
            check("sb_data", out_data, b.data);
            check("sb_sop", 256'(out_sop), 256'(b.sop));
            check("sb_eop", 256'(out_eop), 256'(b.eop));
            acc_log.push_back(cyc);
         end
      end
      for (int i = 0; i < N; i++) acc[i] = reset_n & in_valid[i] & in_ready[i];
   end

   initial begin
      reset_n    = 1'b0;
      hold_all   = 1'b1;
      out_ready  = 1'b1;
      fill_level = 4'd0;

      // Reset with every source valid.
      tick(3);
      check("rst_out_valid", 256'(out_valid), 256'd0);
      check("rst_in_ready", 256'(in_ready), 256'd0);
      check("rst_out_sop", 256'(out_sop), 256'd0);
      check("rst_out_eop", 256'(out_eop), 256'd0);
      check("rst_out_channel", 256'(out_channel), 256'd0);
      check("rst_grant_active", 256'(grant_active), 256'd0);
      check("rst_pkt_count", 256'(pkt_count), 256'd0);
      hold_all = 1'b0;
      reset_n  = 1'b1;
      tick(2);
      check("idle_no_grant", 256'(grant_active), 256'd0);

      // Single 3-beat packet from source 1.
      acc_log.delete();
      c0 = cyc;
      send(1, 3, 3, 1);
      wait_drain(50, "single_drain");
      check("single_beats", 256'(acc_log.size()), 256'd3);
      for (int k = 0; k < 3; k++)
         check("single_beat_cycle", 256'(acc_log[k]), 256'(c0 + 2 + k));
      check("single_pkt_count", 256'(pkt_count), 256'd1);
      check("single_idle", 256'(grant_active), 256'd0);

      // Round robin from a fresh pointer: 0,1,2,3,0 with one bubble each.
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      check("rr_pkt_count_rst", 256'(pkt_count), 256'd0);
      acc_log.delete();
      c0 = cyc;
      send(0, 1, 1, 2);
      send(1, 1, 1, 2);
      send(2, 1, 1, 2);
      send(3, 1, 1, 2);
      send(0, 1, 1, 3);
      wait_drain(100, "rr_drain");
      check("rr_beats", 256'(acc_log.size()), 256'd5);
      for (int k = 0; k < 5; k++)
         check("rr_beat_cycle", 256'(acc_log[k]), 256'(c0 + 2 + 2*k));
      check("rr_pkt_count", 256'(pkt_count), 256'd5);

      // Lock: source 2 waits for source 0's whole packet under backpressure.
      send(0, 4, 4, 4);
      tick(2);
      send(2, 1, 1, 4);
      for (int k = 0; k < 16; k++) begin
         out_ready = ~out_ready;
         #1;
         if (src_pending(0)) begin
            check("lock_in_ready2", 256'(in_ready[2]), 256'd0);
            check("lock_channel", 256'(out_channel), 256'd0);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_drain(50, "lock_drain");
      check("lock_pkt_count", 256'(pkt_count), 256'd7);

      // A valid beat without SOP is never a request.
      begin
         beat_t b;
         b.src = 1; b.data = '1; b.sop = 1'b0; b.eop = 1'b1;
         pend_q.push_back(b);
      end
      tick(5);
      check("nosop_grant", 256'(grant_active), 256'd0);
      check("nosop_valid", 256'(out_valid), 256'd0);
      pend_q.delete();
      tick(1);

      // Threshold: no grant at fill 6, grant the cycle after fill drops to 5.
      fill_level = 4'd6;
      send(3, 2, 2, 5);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("thresh_hold", 256'(grant_active), 256'd0);
      end
      acc_log.delete();
      c0 = cyc;
      fill_level = 4'd5;
      tick(1);
      check("thresh_grant", 256'(grant_active), 256'd1);
      check("thresh_channel", 256'(out_channel), 256'd3);
      fill_level = 4'd15;
      wait_drain(50, "thresh_drain");
      check("thresh_first_beat", 256'(acc_log[0]), 256'(c0 + 2));
      check("thresh_pkt_count", 256'(pkt_count), 256'd8);
      fill_level = 4'd0;

      // Abort: reset after two beats of a 3-beat packet.
      send(2, 3, 2, 6);
      tick(3);
      reset_n = 1'b0;
      #1;
      check("abort_out_valid", 256'(out_valid), 256'd0);
      check("abort_in_ready", 256'(in_ready), 256'd0);
      check("abort_grant_active", 256'(grant_active), 256'd0);
      check("abort_channel", 256'(out_channel), 256'd0);
      check("abort_pkt_count", 256'(pkt_count), 256'd0);
      check("abort_sb_left", 256'(exp_q.size()), 256'd0);
      pend_q.delete();
      exp_q.delete();
      tick(2);
      reset_n = 1'b1;
      tick(2);
      check("abort_idle", 256'(grant_active), 256'd0);

      // Counter wrap, preloading the count near the top.
      force dut.pkt_count = 16'hFFFE;
      #1;
      release dut.pkt_count;
      #1;
      check("wrap_preload", 256'(pkt_count), 256'hFFFE);
      send(0, 1, 1, 7);
      wait_drain(50, "wrap_drain1");
      tick(1);
      check("wrap_ffff", 256'(pkt_count), 256'hFFFF);
      send(1, 1, 1, 7);
      wait_drain(50, "wrap_drain2");
      tick(1);
      check("wrap_zero", 256'(pkt_count), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
